// File: rtl/block_matmul_pkg.sv
// rtl/block_matmul_pkg.sv - shared state encoding, word width and float constants for the block matmul scheduler
package block_matmul_pkg;

    localparam int W = 32;

    localparam logic [W-1:0] FP_ZERO = 32'h0000_0000;
    localparam logic [W-1:0] FP_ONE  = 32'h3f80_0000;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_MUL,
        ADD_REQ,
        ADD_WAIT,
        NEXT,
        DONE
    } state_t;

endpackage

// File: rtl/block_matmul_bank.sv
// rtl/block_matmul_bank.sv - D*D x W register bank with element and 2x2-block write ports and flat read-out
module block_matmul_bank
    import block_matmul_pkg::*;
#(
    parameter int D = 4,
    localparam int AW = $clog2(D * D)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [W-1:0]     wr_data,
    input  logic             blk_wr_en,
    input  logic [AW-1:0]    blk_base,
    input  logic [4*W-1:0]   blk_data,
    output logic [D*D*W-1:0] flat
);

    localparam logic [AW-1:0] ROW = AW'(D);
    localparam logic [AW-1:0] ONE = AW'(1);

    logic [W-1:0] mem [D*D];

    // Block write lands c11/c12 on the top row and c21/c22 one row below.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < D * D; i++) begin
                mem[i] <= '0;
            end
        end else if (blk_wr_en) begin
            mem[blk_base]             <= blk_data[0*W +: W];
            mem[blk_base + ONE]       <= blk_data[1*W +: W];
            mem[blk_base + ROW]       <= blk_data[2*W +: W];
            mem[blk_base + ROW + ONE] <= blk_data[3*W +: W];
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        for (int i = 0; i < D * D; i++) begin
            flat[i*W +: W] = mem[i];
        end
    end

endmodule

// File: rtl/block_matmul_scheduler.sv
// rtl/block_matmul_scheduler.sv - 2x2-block float32 matmul sequencer; BLK_MATMUL_PERF_CNT_EN adds perf_cycles/perf_stall
module block_matmul_scheduler
    import block_matmul_pkg::*;
#(
    parameter int N_BLK = 2,
    localparam int D  = 2 * N_BLK,
    localparam int AW = $clog2(D * D)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic          wr_sel_b,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          start,
    output logic          busy,
    output logic          done,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data,
    output logic [W-1:0]  mul_a11,
    output logic [W-1:0]  mul_a12,
    output logic [W-1:0]  mul_a21,
    output logic [W-1:0]  mul_a22,
    output logic [W-1:0]  mul_b11,
    output logic [W-1:0]  mul_b12,
    output logic [W-1:0]  mul_b21,
    output logic [W-1:0]  mul_b22,
    output logic          mul_start,
    input  logic          mul_done,
    input  logic [W-1:0]  mul_c11,
    input  logic [W-1:0]  mul_c12,
    input  logic [W-1:0]  mul_c21,
    input  logic [W-1:0]  mul_c22,
    output logic [W-1:0]  add_a,
    output logic [W-1:0]  add_b,
    output logic          add_in_stb,
    input  logic          add_in_ack,
    input  logic [W-1:0]  add_z,
    input  logic          add_z_stb,
    output logic          add_z_ack
`ifdef BLK_MATMUL_PERF_CNT_EN
    ,
    output logic [31:0]   perf_cycles,
    output logic [31:0]   perf_stall
`endif
);

    localparam int BW = (N_BLK > 1) ? $clog2(N_BLK) : 1;
    localparam logic [BW-1:0] LAST = BW'(N_BLK - 1);

    state_t           state, state_nx;
    logic [BW-1:0]    bi, bj, bk;
    logic [1:0]       e;
    logic [W-1:0]     p [4];
    logic [D*D*W-1:0] a_flat, b_flat, c_flat;
    int               a_base, b_base, c_base, c_elem;
    logic             a_wr, b_wr, c_wr, c_blk_wr;

    function automatic logic [W-1:0] pick(input logic [D*D*W-1:0] f, input int idx);
        return f[idx*W +: W];
    endfunction

    // Top-left element index of each 2x2 block in row-major order.
    assign a_base = 2 * (int'(bi) * D + int'(bk));
    assign b_base = 2 * (int'(bk) * D + int'(bj));
    assign c_base = 2 * (int'(bi) * D + int'(bj));
    assign c_elem = c_base + (e[1] ? D : 0) + int'(e[0]);

    block_matmul_bank #(.D(D)) u_a_bank (
        .clk(clk), .rst(rst),
        .wr_en(a_wr), .wr_addr(wr_addr), .wr_data(wr_data),
        .blk_wr_en(1'b0), .blk_base('0), .blk_data('0),
        .flat(a_flat)
    );

    block_matmul_bank #(.D(D)) u_b_bank (
        .clk(clk), .rst(rst),
        .wr_en(b_wr), .wr_addr(wr_addr), .wr_data(wr_data),
        .blk_wr_en(1'b0), .blk_base('0), .blk_data('0),
        .flat(b_flat)
    );

    block_matmul_bank #(.D(D)) u_c_bank (
        .clk(clk), .rst(rst),
        .wr_en(c_wr), .wr_addr(AW'(c_elem)), .wr_data(add_z),
        .blk_wr_en(c_blk_wr), .blk_base(AW'(c_base)),
        .blk_data({mul_c22, mul_c21, mul_c12, mul_c11}),
        .flat(c_flat)
    );

    assign rd_data = pick(c_flat, int'(rd_addr));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        busy       = 1'b0;
        done       = 1'b0;
        mul_start  = 1'b0;
        add_in_stb = 1'b0;
        add_z_ack  = 1'b0;
        a_wr       = 1'b0;
        b_wr       = 1'b0;
        c_wr       = 1'b0;
        c_blk_wr   = 1'b0;
        case (state)
            IDLE: begin
                a_wr = wr_en & ~wr_sel_b;
                b_wr = wr_en & wr_sel_b;
                if (start) state_nx = ISSUE;
            end
            ISSUE: begin
                busy      = 1'b1;
                mul_start = 1'b1;
                state_nx  = WAIT_MUL;
            end
            WAIT_MUL: begin
                busy = 1'b1;
                if (mul_done) begin
                    c_blk_wr = (bk == '0);
                    state_nx = (bk == '0) ? NEXT : ADD_REQ;
                end
            end
            ADD_REQ: begin
                busy       = 1'b1;
                add_in_stb = 1'b1;
                if (add_in_ack) state_nx = ADD_WAIT;
            end
            ADD_WAIT: begin
                busy = 1'b1;
                if (add_z_stb) begin
                    add_z_ack = 1'b1;
                    c_wr      = 1'b1;
                    state_nx  = (e == 2'd3) ? NEXT : ADD_REQ;
                end
            end
            NEXT: begin
                busy     = 1'b1;
                state_nx = (bi == LAST && bj == LAST && bk == LAST) ? DONE : ISSUE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        {mul_a11, mul_a12, mul_a21, mul_a22} = '0;
        {mul_b11, mul_b12, mul_b21, mul_b22} = '0;
        add_a = '0;
        add_b = '0;
        if (state == ISSUE || state == WAIT_MUL) begin
            mul_a11 = pick(a_flat, a_base);
            mul_a12 = pick(a_flat, a_base + 1);
            mul_a21 = pick(a_flat, a_base + D);
            mul_a22 = pick(a_flat, a_base + D + 1);
            mul_b11 = pick(b_flat, b_base);
            mul_b12 = pick(b_flat, b_base + 1);
            mul_b21 = pick(b_flat, b_base + D);
            mul_b22 = pick(b_flat, b_base + D + 1);
        end
        if (state == ADD_REQ) begin
            add_a = pick(c_flat, c_elem);
            add_b = p[e];
        end
    end

    // bk is innermost, so the C block only changes once all its partials are in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bi <= '0;
            bj <= '0;
            bk <= '0;
            e  <= '0;
            for (int i = 0; i < 4; i++) begin
                p[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        bi <= '0;
                        bj <= '0;
                        bk <= '0;
                        e  <= '0;
                    end
                end
                WAIT_MUL: begin
                    if (mul_done) begin
                        p[0] <= mul_c11;
                        p[1] <= mul_c12;
                        p[2] <= mul_c21;
                        p[3] <= mul_c22;
                        e    <= '0;
                    end
                end
                ADD_WAIT: begin
                    if (add_z_stb) e <= e + 2'd1;
                end
                NEXT: begin
                    if (bk == LAST) begin
                        bk <= '0;
                        if (bj == LAST) begin
                            bj <= '0;
                            bi <= (bi == LAST) ? '0 : bi + BW'(1);
                        end else begin
                            bj <= bj + BW'(1);
                        end
                    end else begin
                        bk <= bk + BW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BLK_MATMUL_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else if (state == IDLE && start) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else begin
            if (busy && !(&perf_cycles)) perf_cycles <= perf_cycles + 32'd1;
            if ((state == WAIT_MUL || state == ADD_WAIT) && !(&perf_stall))
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule
